// File: rtl/r2_inv_butterfly.sv
// Radix-2 inverse butterfly: a = (s1+s2)/2, b = conj(W)*(s1-s2)/2.
// Three-stage valid-tagged pipeline with a global clock-enable stall.
module r2_inv_butterfly #(
  parameter int DW = 18,
  parameter int TF = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 valid_in,
  input  logic signed [DW-1:0] s1r,
  input  logic signed [DW-1:0] s1i,
  input  logic signed [DW-1:0] s2r,
  input  logic signed [DW-1:0] s2i,
  input  logic signed [DW-1:0] wr,
  input  logic signed [DW-1:0] wi,
  output logic signed [DW-1:0] ar,
  output logic signed [DW-1:0] ai,
  output logic signed [DW-1:0] br,
  output logic signed [DW-1:0] bi,
  output logic                 valid_out
);

  localparam int SW = 2*DW + 2;
  localparam logic signed [SW-1:0] SMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] ONE  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] RND  = ONE <<< (TF-1);

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] x);
    if (x > SMAX)      sat = SMAX[DW-1:0];
    else if (x < SMIN) sat = SMIN[DW-1:0];
    else               sat = x[DW-1:0];
  endfunction

  // Round-half-up halving of a 19-bit sum/difference.
  function automatic logic signed [DW-1:0] half(input logic signed [DW:0] x);
    logic signed [SW-1:0] t;
    t = SW'(x) + ONE;
    half = sat(t >>> 1);
  endfunction

  logic [2:0] vld;

  logic signed [DW:0]     sum_r, sum_i, diff_r, diff_i;
  logic signed [DW-1:0]   w1r, w1i;

  logic signed [DW-1:0]   a2r, a2i;
  logic signed [2*DW-1:0] p_rr, p_ii, p_ir, p_ri;

  logic signed [DW-1:0]   d_r, d_i;
  logic signed [SW-1:0]   acc_r, acc_i;

  always_comb begin
    d_r   = half(diff_r);
    d_i   = half(diff_i);
    acc_r = SW'(p_rr) + SW'(p_ii);
    acc_i = SW'(p_ir) - SW'(p_ri);
  end

  assign valid_out = vld[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld    <= '0;
      sum_r  <= '0;
      sum_i  <= '0;
      diff_r <= '0;
      diff_i <= '0;
      w1r    <= '0;
      w1i    <= '0;
      a2r    <= '0;
      a2i    <= '0;
      p_rr   <= '0;
      p_ii   <= '0;
      p_ir   <= '0;
      p_ri   <= '0;
      ar     <= '0;
      ai     <= '0;
      br     <= '0;
      bi     <= '0;
    end else if (ce) begin
      vld    <= {vld[1:0], valid_in};

      sum_r  <= {s1r[DW-1], s1r} + {s2r[DW-1], s2r};
      sum_i  <= {s1i[DW-1], s1i} + {s2i[DW-1], s2i};
      diff_r <= {s1r[DW-1], s1r} - {s2r[DW-1], s2r};
      diff_i <= {s1i[DW-1], s1i} - {s2i[DW-1], s2i};
      w1r    <= wr;
      w1i    <= wi;

      a2r    <= half(sum_r);
      a2i    <= half(sum_i);
      p_rr   <= d_r * w1r;
      p_ii   <= d_i * w1i;
      p_ir   <= d_i * w1r;
      p_ri   <= d_r * w1i;

      // conj(W): real = dr*wr + di*wi, imag = di*wr - dr*wi
      ar     <= a2r;
      ai     <= a2i;
      br     <= sat((acc_r + RND) >>> TF);
      bi     <= sat((acc_i + RND) >>> TF);
    end
  end

endmodule
